// File: rtl/uart_pkg.sv
// Shared UART types and helpers: FSM states, parity constants, length-mask/parity function.
// Pure declarations; no latency or backpressure of its own.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_MAX_WIDTH  = 16;
    localparam int UART_MAX_CNT_W  = 5;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef struct packed {
        logic [UART_MAX_WIDTH-1:0] word;
        logic                      parity;
    } masked_word_t;

    function automatic int uart_cnt_w(input int data_width);
        return $clog2(data_width + 1);
    endfunction

    // Bits at index >= len are cleared; parity covers only the surviving bits.
    function automatic masked_word_t uart_mask_word(
        input logic [UART_MAX_WIDTH-1:0] data,
        input logic [UART_MAX_CNT_W-1:0] len,
        input logic                      par_odd
    );
        masked_word_t res;
        for (int i = 0; i < UART_MAX_WIDTH; i++) begin
            res.word[i] = data[i] & (i < int'(len));
        end
        res.parity = (^res.word) ^ par_odd;
        return res;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_p.sv
// UART TX serializer: loads a word on valid/ready, shifts one bit per ser_tick, parity at load.
// First bit 1 cycle after accept; load_ready only in IDLE, so loads while shifting are not taken.
module uart_tx_serializer_p
    import uart_pkg::*;
#(
    parameter int   DATA_WIDTH = UART_DATA_WIDTH,
    parameter int   MSB_FIRST  = 0,
    parameter logic IDLE_LEVEL = 1'b1,
    localparam int  CNT_W      = uart_cnt_w(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic [CNT_W-1:0]      data_len,
    input  logic                  par_odd,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic                  ser_tick,
    output logic                  ser_data,
    output logic                  ser_busy,
    output logic                  ser_done,
    output logic                  par_bit
);

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [CNT_W-1:0]      len_q, len_nxt;
    logic [CNT_W-1:0]      len_eff;
    logic                  data_nxt, busy_nxt, done_nxt, par_nxt;
    logic                  next_bit;
    logic [DATA_WIDTH-1:0] shreg_shifted;
    masked_word_t          masked;
    logic [DATA_WIDTH-1:0] word, word_msb;

    // Zero or oversize lengths fall back to the full width.
    assign len_eff = (data_len != '0 && data_len <= CNT_W'(DATA_WIDTH))
                   ? data_len : CNT_W'(DATA_WIDTH);

    assign masked   = uart_mask_word(UART_MAX_WIDTH'(p_data), UART_MAX_CNT_W'(len_eff),
                                     par_odd == PAR_ODD);
    assign word     = masked.word[DATA_WIDTH-1:0];
    assign word_msb = word << (CNT_W'(DATA_WIDTH) - len_eff);

    generate
        if (DATA_WIDTH < UART_MAX_WIDTH) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = |masked.word[UART_MAX_WIDTH-1:DATA_WIDTH];
        end
    endgenerate

    // MSB-first keeps the word left-aligned so the next bit is always the top bit.
    assign next_bit      = (MSB_FIRST != 0) ? shreg[DATA_WIDTH-1] : shreg[0];
    assign shreg_shifted = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);

    assign load_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        len_nxt   = len_q;
        data_nxt  = ser_data;
        busy_nxt  = ser_busy;
        done_nxt  = 1'b0;
        par_nxt   = par_bit;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    state_nxt = SHIFT;
                    len_nxt   = len_eff;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                    par_nxt   = masked.parity;
                    if (MSB_FIRST != 0) begin
                        data_nxt  = word_msb[DATA_WIDTH-1];
                        shreg_nxt = word_msb << 1;
                    end else begin
                        data_nxt  = word[0];
                        shreg_nxt = word >> 1;
                    end
                end
            end
            SHIFT: begin
                if (ser_tick) begin
                    if (cnt == len_q - CNT_W'(1)) begin
                        state_nxt = IDLE;
                        data_nxt  = IDLE_LEVEL;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt   = cnt + CNT_W'(1);
                        data_nxt  = next_bit;
                        shreg_nxt = shreg_shifted;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg    <= '0;
            cnt      <= '0;
            len_q    <= '0;
            ser_data <= IDLE_LEVEL;
            ser_busy <= 1'b0;
            ser_done <= 1'b0;
            par_bit  <= 1'b0;
        end else begin
            shreg    <= shreg_nxt;
            cnt      <= cnt_nxt;
            len_q    <= len_nxt;
            ser_data <= data_nxt;
            ser_busy <= busy_nxt;
            ser_done <= done_nxt;
            par_bit  <= par_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer_p.sv
// Bench for uart_tx_serializer_p: LSB-first and MSB-first builds driven in lockstep,
// checked against a bit-list reference model of each transmitted character.
module tb_uart_tx_serializer_p;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic [DW-1:0] p_data;
    logic [CW-1:0] data_len;
    logic          par_odd;
    logic          load_valid;
    logic          ser_tick;
    logic          load_ready, ser_data, ser_busy, ser_done, par_bit;
    logic          load_ready_m, ser_data_m, ser_busy_m, ser_done_m, par_bit_m;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_serializer_p #(.DATA_WIDTH(DW), .MSB_FIRST(0), .IDLE_LEVEL(1'b1)) dut (
        .clk(clk), .rst(rst), .p_data(p_data), .data_len(data_len), .par_odd(par_odd),
        .load_valid(load_valid), .load_ready(load_ready), .ser_tick(ser_tick),
        .ser_data(ser_data), .ser_busy(ser_busy), .ser_done(ser_done), .par_bit(par_bit)
    );

    uart_tx_serializer_p #(.DATA_WIDTH(DW), .MSB_FIRST(1), .IDLE_LEVEL(1'b1)) dut_m (
        .clk(clk), .rst(rst), .p_data(p_data), .data_len(data_len), .par_odd(par_odd),
        .load_valid(load_valid), .load_ready(load_ready_m), .ser_tick(ser_tick),
        .ser_data(ser_data_m), .ser_busy(ser_busy_m), .ser_done(ser_done_m), .par_bit(par_bit_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // Reference: transmitted bit list in wire order, effective length, expected parity.
    task automatic model(input logic [15:0] p, input int dlen, input logic odd, input bit msb,
                         output logic [15:0] bits, output int len, output logic par);
        logic [15:0] w;
        len  = (dlen >= 1 && dlen <= DW) ? dlen : DW;
        w    = p & ((16'd1 << len) - 16'd1);
        par  = odd ^ (($countones(w) % 2) != 0);
        bits = '0;
        for (int i = 0; i < len; i++) bits[i] = msb ? w[len-1-i] : w[i];
    endtask

    task automatic do_load(input string name, input logic [15:0] p, input int dlen, input logic odd);
        p_data     = p[DW-1:0];
        data_len   = CW'(dlen);
        par_odd    = odd;
        load_valid = 1'b1;
        n_cmp++;
        if (load_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s load_ready: got %b expected 1", name, load_ready);
        end
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // Checks every cycle of a character, ends at the negedge of the done cycle.
    task automatic shift_check(input string name, input logic [15:0] bits, input int len,
                               input int period, input logic par, input bit use_m,
                               input bit noise, input bit keep_valid);
        logic sd, bz, dn, rd, pb;
        for (int i = 0; i < len; i++) begin
            for (int c = 0; c < period; c++) begin
                sd = use_m ? ser_data_m   : ser_data;
                bz = use_m ? ser_busy_m   : ser_busy;
                dn = use_m ? ser_done_m   : ser_done;
                rd = use_m ? load_ready_m : load_ready;
                pb = use_m ? par_bit_m    : par_bit;
                n_cmp++;
                if (sd !== bits[i]) begin
                    n_err++;
                    $display("FAIL %s bit%0d cyc%0d ser_data: got %b expected %b", name, i, c, sd, bits[i]);
                end
                n_cmp++;
                if ({bz, dn, rd, pb} !== {1'b1, 1'b0, 1'b0, par}) begin
                    n_err++;
                    $display("FAIL %s bit%0d cyc%0d busy/done/ready/par: got %b expected %b",
                             name, i, c, {bz, dn, rd, pb}, {1'b1, 1'b0, 1'b0, par});
                end
                ser_tick = (c == period - 1);
                if (noise) begin
                    load_valid = 1'($urandom_range(0, 1));
                    p_data     = DW'($urandom);
                    data_len   = CW'($urandom);
                    par_odd    = 1'($urandom);
                end
                @(negedge clk);
            end
        end
        ser_tick = 1'b0;
        if (!keep_valid) load_valid = 1'b0;
        sd = use_m ? ser_data_m   : ser_data;
        bz = use_m ? ser_busy_m   : ser_busy;
        dn = use_m ? ser_done_m   : ser_done;
        rd = use_m ? load_ready_m : load_ready;
        pb = use_m ? par_bit_m    : par_bit;
        n_cmp++;
        if ({sd, bz, dn, rd, pb} !== {1'b1, 1'b0, 1'b1, 1'b1, par}) begin
            n_err++;
            $display("FAIL %s done cycle data/busy/done/ready/par: got %b expected %b",
                     name, {sd, bz, dn, rd, pb}, {1'b1, 1'b0, 1'b1, 1'b1, par});
        end
    endtask

    task automatic post_done(input string name, input bit use_m, input logic par);
        logic sd, bz, dn, rd, pb;
        @(negedge clk);
        sd = use_m ? ser_data_m   : ser_data;
        bz = use_m ? ser_busy_m   : ser_busy;
        dn = use_m ? ser_done_m   : ser_done;
        rd = use_m ? load_ready_m : load_ready;
        pb = use_m ? par_bit_m    : par_bit;
        n_cmp++;
        if ({sd, bz, dn, rd, pb} !== {1'b1, 1'b0, 1'b0, 1'b1, par}) begin
            n_err++;
            $display("FAIL %s after done data/busy/done/ready/par: got %b expected %b",
                     name, {sd, bz, dn, rd, pb}, {1'b1, 1'b0, 1'b0, 1'b1, par});
        end
    endtask

    task automatic send(input string name, input logic [15:0] p, input int dlen, input logic odd,
                        input int period, input bit use_m, input bit noise);
        logic [15:0] bits;
        int          len;
        logic        par;
        model(p, dlen, odd, use_m, bits, len, par);
        do_load(name, p, dlen, odd);
        shift_check(name, bits, len, period, par, use_m, noise, 1'b0);
        post_done(name, use_m, par);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ser_data, ser_busy, ser_done, load_ready, par_bit} !== 5'b10010) begin
            n_err++;
            $display("FAIL reset_lsb: got %b expected 10010",
                     {ser_data, ser_busy, ser_done, load_ready, par_bit});
        end
        n_cmp++;
        if ({ser_data_m, ser_busy_m, ser_done_m, load_ready_m, par_bit_m} !== 5'b10010) begin
            n_err++;
            $display("FAIL reset_msb: got %b expected 10010",
                     {ser_data_m, ser_busy_m, ser_done_m, load_ready_m, par_bit_m});
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle;
        for (int i = 0; i < 20; i++) begin
            ser_tick = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_cmp++;
            if ({ser_data, ser_busy, ser_done, load_ready} !== 4'b1001) begin
                n_err++;
                $display("FAIL idle cyc%0d data/busy/done/ready: got %b expected 1001",
                         i, {ser_data, ser_busy, ser_done, load_ready});
            end
        end
        ser_tick = 1'b0;
    endtask

    task automatic test_lsb_a5;
        send("lsb_a5", 16'h00A5, 8, 1'b0, 4, 1'b0, 1'b0);
    endtask

    task automatic test_lengths;
        send("len5_ff", 16'h00FF, 5, 1'b1, 3, 1'b0, 1'b0);
        send("len0_ff", 16'h00FF, 0, 1'b1, 2, 1'b0, 1'b0);
        send("len12_ff", 16'h00FF, 12, 1'b1, 2, 1'b0, 1'b0);
        send("len1", 16'h00FE, 1, 1'b0, 3, 1'b0, 1'b0);
        send("len1_odd", 16'h0001, 1, 1'b1, 1, 1'b1, 1'b0);
    endtask

    task automatic test_msb_first;
        send("msb_81", 16'h0081, 8, 1'b0, 4, 1'b1, 1'b0);
        send("msb_b2_len5", 16'h00B2, 5, 1'b0, 2, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [15:0] bits1, bits2;
        int          len1, len2;
        logic        par1, par2;
        model(16'h000F, 8, 1'b0, 1'b0, bits1, len1, par1);
        model(16'h00F0, 8, 1'b1, 1'b0, bits2, len2, par2);
        p_data     = 8'h0F;
        data_len   = 4'd8;
        par_odd    = 1'b0;
        load_valid = 1'b1;
        n_cmp++;
        if (load_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b first load_ready: got %b expected 1", load_ready);
        end
        @(negedge clk);
        p_data  = 8'hF0;
        par_odd = 1'b1;
        shift_check("b2b_w1", bits1, len1, 3, par1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        load_valid = 1'b0;
        shift_check("b2b_w2", bits2, len2, 3, par2, 1'b0, 1'b0, 1'b0);
        post_done("b2b_w2", 1'b0, par2);
    endtask

    task automatic test_reset_mid_word;
        logic [15:0] bits;
        int          len;
        logic        par;
        model(16'h003C, 8, 1'b0, 1'b0, bits, len, par);
        do_load("rst_mid", 16'h003C, 8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 2; c++) begin
                n_cmp++;
                if (ser_data !== bits[i]) begin
                    n_err++;
                    $display("FAIL rst_mid bit%0d ser_data: got %b expected %b", i, ser_data, bits[i]);
                end
                ser_tick = (c == 1);
                @(negedge clk);
            end
        end
        ser_tick = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({ser_data, ser_busy, ser_done, load_ready, par_bit} !== 5'b10010) begin
            n_err++;
            $display("FAIL rst_mid async: got %b expected 10010",
                     {ser_data, ser_busy, ser_done, load_ready, par_bit});
        end
        for (int i = 0; i < 6; i++) begin
            if (i == 2) rst = 1'b1;
            ser_tick = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_cmp++;
            if ({ser_data, ser_busy, ser_done, load_ready} !== 4'b1001) begin
                n_err++;
                $display("FAIL rst_mid after cyc%0d data/busy/done/ready: got %b expected 1001",
                         i, {ser_data, ser_busy, ser_done, load_ready});
            end
        end
        ser_tick = 1'b0;
        send("rst_fresh", 16'h003C, 8, 1'b1, 3, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            send("rand", 16'($urandom_range(0, 255)), $urandom_range(0, 15), 1'($urandom),
                 $urandom_range(1, 4), 1'($urandom), 1'b1);
        end
    endtask

    initial begin
        rst        = 1'b0;
        p_data     = '0;
        data_len   = '0;
        par_odd    = 1'b0;
        load_valid = 1'b0;
        ser_tick   = 1'b0;
        test_reset;
        test_idle;
        test_lsb_a5;
        test_lengths;
        test_msb_first;
        test_back_to_back;
        test_reset_mid_word;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
